// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and grant owner.
// The cache controller imports this package too, so keep the encodings stable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } arb_gnt_e;

    // MEM is older than IF in the pipe, so a pending data access always wins.
    function automatic arb_gnt_e arb_pick(input logic d_req);
        return d_req ? GntD : GntI;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and load/store.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with a per-transaction response timeout.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              timeout_err
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              timeout_q, timeout_d;

    logic              resp_hit;
    logic              cnt_expired;
    logic [DATA_W-1:0] resp_data;

    // A response arriving on the same cycle the counter expires takes precedence.
    assign resp_hit    = (state_q == StWait) && m_resp_valid;
    assign cnt_expired = (state_q == StWait) && !m_resp_valid && (cnt_q == CntMax);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (d_req || i_req)              state_d = StIssue;
            StIssue: if (m_req_ready)                 state_d = StWait;
            StWait:  if (resp_hit || cnt_expired)     state_d = StDone;
            StDone:                                   state_d = StIdle;
            default:                                  state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; the request fields come straight from the latch.
    always_comb begin
        m_req_valid = (state_q == StIssue);
        i_ready     = (state_q == StDone) && (gnt_q == GntI);
        d_ready     = (state_q == StDone) && (gnt_q == GntD);
    end

    assign m_we        = we_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = timeout_q;

    // Request latch, wait counter and response capture
    always_comb begin
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        timeout_d = timeout_q;
        resp_data = (resp_hit && !we_q) ? m_rdata : '0;

        if ((state_q == StIdle) && (d_req || i_req)) begin
            gnt_d = arb_pick(d_req);
            if (d_req) begin
                we_d    = d_we;
                addr_d  = d_addr;
                wdata_d = d_wdata;
            end else begin
                we_d    = 1'b0;
                addr_d  = i_addr;
                wdata_d = '0;
            end
        end

        if ((state_q == StIssue) && m_req_ready) begin
            cnt_d = '0;
        end else if ((state_q == StWait) && !resp_hit && !cnt_expired) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Stores and timeouts both return zero to the requester.
        if (resp_hit || cnt_expired) begin
            if (gnt_q == GntD) begin
                d_rdata_d = resp_data;
            end else begin
                i_rdata_d = resp_data;
            end
        end

        if (cnt_expired) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q     <= GntI;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            timeout_q <= timeout_d;
        end
    end

    a_ready_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(i_ready && d_ready));

    a_req_held: assert property (@(posedge clk) disable iff (reset)
        (m_req_valid && !m_req_ready) |=>
            (m_req_valid && $stable(m_we) && $stable(m_addr) && $stable(m_wdata)));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a vector table of single transactions plus
// hand-written contention and reset-during-wait sequences.
module tb_unified_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          m_req_valid;
    logic          m_req_ready;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_resp_valid;
    logic [DW-1:0] m_rdata;
    logic          timeout_err;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ready      (i_ready),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ready      (d_ready),
        .d_rdata      (d_rdata),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_resp_valid (m_resp_valid),
        .m_rdata      (m_rdata),
        .timeout_err  (timeout_err)
    );

    // One transaction: who asks, what, how the memory behaves, and what must come back.
    // exp_lat counts cycles from the IDLE cycle that samples the request to the ready pulse.
    typedef struct {
        bit          d_side;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_data;
        int          acc_wait;
        int          resp_wait;
        bit          no_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    localparam int NVec = 7;
    vec_t vecs [NVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          acc_cnt      = 0;
        int          resp_cnt     = 0;
        int          valid_cycles = 0;
        int          ready_cyc    = -1;
        int          pulses       = 0;
        bit          in_wait      = 0;
        bit          done         = 0;
        bit          fields_ok    = 1;
        bit          other_rdy    = 0;
        logic [31:0] got_rdata    = '0;
        logic [31:0] exp_wdata;
        string       tag;
        tag       = $sformatf("vec%0d", idx);
        exp_wdata = v.d_side ? v.wdata : 32'h0;
        @(negedge clk);
        if (v.d_side) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            m_resp_valid = 1'b0;
            m_rdata      = '0;
            if (in_wait && !v.no_resp) begin
                if (resp_cnt == v.resp_wait) begin
                    m_resp_valid = 1'b1;
                    m_rdata      = v.mem_data;
                    in_wait      = 0;
                end else begin
                    resp_cnt++;
                end
            end
            m_req_ready = 1'b0;
            if (m_req_valid) begin
                valid_cycles++;
                if (m_we !== v.we || m_addr !== v.addr || m_wdata !== exp_wdata) fields_ok = 0;
                if (acc_cnt == v.acc_wait) begin
                    m_req_ready = 1'b1;
                    in_wait     = 1;
                end else begin
                    acc_cnt++;
                end
            end
            if (v.d_side ? i_ready : d_ready) other_rdy = 1;
            if (v.d_side ? d_ready : i_ready) begin
                ready_cyc = cyc;
                pulses++;
                done      = 1;
                got_rdata = v.d_side ? d_rdata : i_rdata;
                d_req     = 1'b0;
                i_req     = 1'b0;
            end
            @(negedge clk);
        end
        m_resp_valid = 1'b0;
        m_req_ready  = 1'b0;
        if (v.d_side ? d_ready : i_ready) pulses++;
        if (v.d_side ? i_ready : d_ready) other_rdy = 1;
        if (!done) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        chk({tag, " ready_latency"}, ready_cyc, v.exp_lat);
        chk({tag, " ready_pulses"}, pulses, 1);
        chk({tag, " rdata"}, got_rdata, v.exp_rdata);
        chk({tag, " valid_cycles"}, valid_cycles, v.acc_wait + 1);
        chk({tag, " req_fields"}, {31'b0, fields_ok}, 32'd1);
        chk({tag, " other_ready_quiet"}, {31'b0, other_rdy}, 32'd0);
        chk({tag, " timeout_err"}, {31'b0, timeout_err}, {31'b0, v.exp_err});
    endtask

    initial begin
        int          d_cyc, i_cyc, n_d, n_i, first_seen;
        logic [31:0] first_addr, last_addr, d_data, i_data;
        bit          acc_prev, any_ready, any_valid;

        //                d  we  addr          wdata         mem_data      acc rsp nr  exp_rdata     lat err
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h00A0_0093, 0, 0, 1'b0, 32'h00A0_0093, 3, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0,         3, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'hA5A5_A5A5, 32'hCAFE_F00D, 5, 0, 1'b0, 32'hCAFE_F00D, 8, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'h1122_3344, 0, 3, 1'b0, 32'h1122_3344, 6, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        32'h55AA_55AA, 0, 8, 1'b0, 32'h55AA_55AA, 11, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0,        32'h9999_9999, 0, 0, 1'b1, 32'h0,         11, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        32'h0BAD_C0DE, 0, 0, 1'b0, 32'h0BAD_C0DE, 3, 1'b1};

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; m_req_ready = 1'b0; m_resp_valid = 1'b0; m_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst i_ready", {31'b0, i_ready}, 32'd0);
        chk("rst d_ready", {31'b0, d_ready}, 32'd0);
        chk("rst m_req_valid", {31'b0, m_req_valid}, 32'd0);
        chk("rst m_we", {31'b0, m_we}, 32'd0);
        chk("rst m_addr", m_addr, 32'h0);
        chk("rst m_wdata", m_wdata, 32'h0);
        chk("rst rdata", i_rdata | d_rdata, 32'h0);
        chk("rst timeout_err", {31'b0, timeout_err}, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < NVec; k++) run_txn(k, vecs[k]);

        // Contention: both rise together; D completes first, then I in the next IDLE.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_010C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_wdata = '0;
        d_cyc = -1; i_cyc = -1; n_d = 0; n_i = 0; first_seen = 0;
        first_addr = '0; last_addr = '0; d_data = '0; i_data = '0; acc_prev = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            m_resp_valid = acc_prev;
            m_rdata      = (last_addr == 32'h0000_0200) ? 32'hDEAD_BEEF : 32'h0000_0013;
            acc_prev     = 0;
            m_req_ready  = m_req_valid;
            if (m_req_valid) begin
                if (first_seen == 0) first_addr = m_addr;
                first_seen = 1;
                last_addr  = m_addr;
                acc_prev   = 1;
            end
            if (d_ready) begin d_cyc = cyc; d_data = d_rdata; d_req = 1'b0; n_d++; end
            if (i_ready) begin i_cyc = cyc; i_data = i_rdata; i_req = 1'b0; n_i++; end
            @(negedge clk);
        end
        m_req_ready = 1'b0; m_resp_valid = 1'b0;
        chk("cont first_issue_addr", first_addr, 32'h0000_0200);
        chk("cont d_ready_cycle", d_cyc, 3);
        chk("cont i_ready_cycle", i_cyc, 7);
        chk("cont d_rdata", d_data, 32'hDEAD_BEEF);
        chk("cont i_rdata", i_data, 32'h0000_0013);
        chk("cont pulse_counts", n_d * 16 + n_i, 17);
        chk("cont d_rdata_held", d_rdata, 32'hDEAD_BEEF);

        // Reset while waiting for a response, then a stale response arrives.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0400;
        @(negedge clk);
        m_req_ready = 1'b1;
        @(negedge clk);
        m_req_ready = 1'b0;
        reset = 1'b1; i_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        any_ready = 0; any_valid = 0;
        for (int k = 0; k < 6; k++) begin
            m_resp_valid = (k == 2);
            m_rdata      = (k == 2) ? 32'h7777_7777 : 32'h0;
            if (i_ready || d_ready) any_ready = 1;
            if (m_req_valid) any_valid = 1;
            @(negedge clk);
        end
        m_resp_valid = 1'b0;
        chk("rstwait no_ready", {31'b0, any_ready}, 32'd0);
        chk("rstwait no_issue", {31'b0, any_valid}, 32'd0);
        chk("rstwait i_rdata", i_rdata, 32'h0);
        chk("rstwait d_rdata", d_rdata, 32'h0);
        chk("rstwait m_addr", m_addr, 32'h0);
        chk("rstwait timeout_err", {31'b0, timeout_err}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
